// File: rtl/hdmi_video_timing_pkg.sv
// hdmi_video_timing_pkg: 640x480 timing defaults, derived totals,
// FSM state type and the {de,hs,vs} bundle shared by the timing slice.
package hdmi_video_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL =
    DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL =
    DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

  localparam int BUNDLE_W = 3;

  typedef struct packed {
    logic de;
    logic hs;
    logic vs;
  } vbundle_t;

  typedef enum logic {
    ST_RUN,
    ST_WAIT
  } state_t;

endpackage

// File: rtl/hdmi_video_timing_if.sv
// hdmi_video_timing_if: pixel strobe / frame flag in, video timing out.
// master = timing generator, slave = consumer that drives PixEn/FraimSync.
interface hdmi_video_timing_if;
  logic PixEn;
  logic FraimSync;
  logic HVsync;
  logic HMemRead;
  logic pVDE;
  logic hsync;
  logic vsync;
  logic FrameStart;

  modport master (
    input  PixEn, FraimSync,
    output HVsync, HMemRead, pVDE,
    output hsync, vsync, FrameStart
  );

  modport slave (
    output PixEn, FraimSync,
    input  HVsync, HMemRead, pVDE,
    input  hsync, vsync, FrameStart
  );
endinterface

// File: rtl/hdmi_video_timing_delay_line.sv
// video_delay_line: W-bit, D-deep shift register advancing only on en.
// Ports: clk, rstn (async low, clears to 0), en, d in, q = last stage.
module video_delay_line #(
  parameter int W = 3,
  parameter int D = 3
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] sr [D];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < D; i++) sr[i] <= '0;
    end else if (en) begin
      sr[0] <= d;
      for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
    end
  end

  assign q = sr[D-1];

endmodule

// File: rtl/hdmi_video_timing.sv
// hdmi_video_timing: PixEn-paced H/V counters, registered decode, and
// READ_LEAD-delayed pVDE/hsync/vsync. Ports: clk, rstn, vid (master).
// Optional FRAME_LOCK_EN: hold at (0,0) each frame end until FraimSync edge.
module hdmi_video_timing
  import hdmi_video_timing_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter int READ_LEAD = 3,
  parameter int SYNC_POL  = 0
) (
  input logic clk,
  input logic rstn,
  hdmi_video_timing_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  // delay line holds active-high flags; this flips them for active-low
  localparam logic SYNC_LO = (SYNC_POL == 0);

  state_t          state_q, state_d;
  logic [HW-1:0]   hcnt_q;
  logic [VW-1:0]   vcnt_q;
  vbundle_t        raw, dec_q, dly_q;
  logic            hvs_raw, hvs_q, fs_q;
  logic            issue, blank, last_px;
  logic            pend_q;

  assign last_px = (hcnt_q == H_LAST) && (vcnt_q == V_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
`ifdef FRAME_LOCK_EN
    unique case (state_q)
      ST_RUN:  if (vid.PixEn && last_px) state_d = ST_WAIT;
      ST_WAIT: if (vid.PixEn && pend_q)  state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
`endif
  end

  always_comb begin
    issue = 1'b0;
    blank = 1'b0;
    unique case (state_q)
      ST_RUN:  issue = vid.PixEn;
      ST_WAIT: begin
        issue = vid.PixEn && pend_q;
        blank = vid.PixEn && !pend_q;
      end
      default: ;
    endcase
  end

`ifdef FRAME_LOCK_EN
  logic fsync_q, fsync_edge, clr_pend;

  assign fsync_edge = vid.FraimSync ^ fsync_q;
  assign clr_pend   = issue && (state_q == ST_WAIT);

  // a new edge wins over the clear so no toggle is ever lost
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fsync_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      fsync_q <= vid.FraimSync;
      pend_q  <= fsync_edge | (pend_q & ~clr_pend);
    end
  end
`else
  logic unused_fsync;
  assign unused_fsync = vid.FraimSync;
  assign pend_q       = 1'b0;
`endif

  always_comb begin
    raw.de  = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
    raw.hs  = (hcnt_q >= H_SS) && (hcnt_q < H_SE);
    raw.vs  = (vcnt_q >= V_SS) && (vcnt_q < V_SE);
    hvs_raw = (vcnt_q < V_ACT);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hcnt_q <= '0;
      vcnt_q <= '0;
    end else if (issue) begin
      if (hcnt_q == H_LAST) begin
        hcnt_q <= '0;
        vcnt_q <= (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
      end else begin
        hcnt_q <= hcnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      dec_q <= '0;
      hvs_q <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      fs_q <= issue && (hcnt_q == '0) && (vcnt_q == '0);
      if (issue) begin
        dec_q <= raw;
        hvs_q <= hvs_raw;
      end else if (blank) begin
        dec_q <= '0;
        hvs_q <= 1'b0;
      end
    end
  end

  video_delay_line #(
    .W (BUNDLE_W),
    .D (READ_LEAD)
  ) u_dly (
    .clk  (clk),
    .rstn (rstn),
    .en   (vid.PixEn),
    .d    (dec_q),
    .q    (dly_q)
  );

  assign vid.HMemRead   = dec_q.de;
  assign vid.HVsync     = hvs_q;
  assign vid.FrameStart = fs_q;
  assign vid.pVDE       = dly_q.de;
  assign vid.hsync      = dly_q.hs ^ SYNC_LO;
  assign vid.vsync      = dly_q.vs ^ SYNC_LO;

endmodule

// File: tb/tb_hdmi_video_timing.sv
// tb_hdmi_video_timing: directed bench on a reduced 16x9-tick raster.
// PixEn every 5th clk plus a continuous-PixEn burst; FRAME_LOCK_EN aware.
module tb_hdmi_video_timing;

  localparam int HA = 8, HF = 2, HS = 3, HB = 3;
  localparam int VA = 4, VF = 1, VS = 2, VB = 2;
  localparam int HT = 16, VT = 9, FT = 144, RL = 3;

  logic clk, rstn;
  hdmi_video_timing_if vif();

  hdmi_video_timing #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .READ_LEAD (RL), .SYNC_POL (0)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .vid  (vif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;
  int p, cnt_de, pv_run, last_fs_p, p_hmr1, p_pv1;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d (p=%0d)", tag, got, exp, p);
    end
  endtask

  // hand-written raster: pixel index p -> (h,v) on a 16x9 grid
  function automatic int m_de(input int q);
    if (q < 0) return 0;
    return ((q % HT) < HA && ((q / HT) % VT) < VA) ? 1 : 0;
  endfunction
  function automatic int m_hs(input int q);
    if (q < 0) return 0;
    return ((q % HT) >= 10 && (q % HT) <= 12) ? 1 : 0;
  endfunction
  function automatic int m_vs(input int q);
    int v;
    if (q < 0) return 0;
    v = (q / HT) % VT;
    return (v == 5 || v == 6) ? 1 : 0;
  endfunction
  function automatic int m_hvs(input int q);
    return (((q / HT) % VT) < VA) ? 1 : 0;
  endfunction

  task automatic clr_track();
    p = 0; cnt_de = 0; pv_run = 0;
    last_fs_p = -1; p_hmr1 = -1; p_pv1 = -1;
  endtask

  task automatic chk_px();
    chk("HMemRead", vif.HMemRead, m_de(p));
    chk("HVsync", vif.HVsync, m_hvs(p));
    chk("FrameStart", vif.FrameStart, (p % FT == 0) ? 1 : 0);
    chk("pVDE", vif.pVDE, m_de(p - RL));
    chk("hsync", vif.hsync, 1 - m_hs(p - RL));
    chk("vsync", vif.vsync, 1 - m_vs(p - RL));
    if (vif.HMemRead) begin
      cnt_de++;
      if (p_hmr1 < 0) p_hmr1 = p;
    end
    if (vif.pVDE) begin
      if (p_pv1 < 0) begin
        p_pv1 = p;
        chk("pvde_lead", p_pv1 - p_hmr1, RL);
      end
      pv_run++;
    end else if (pv_run > 0) begin
      chk("pvde_run", pv_run, HA);
      pv_run = 0;
    end
    if (vif.FrameStart) begin
      if (last_fs_p >= 0) chk("frame_period", p - last_fs_p, FT);
      last_fs_p = p;
    end
  endtask

  // called just after a posedge; gap = idle clks between PixEn strobes
  task automatic run(input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      vif.PixEn = 1'b1;
      @(posedge clk); #1;
      if (gap > 0) vif.PixEn = 1'b0;
      chk_px();
      for (int g = 0; g < gap; g++) begin
        @(posedge clk); #1;
        if (g == 0) begin
          chk("FrameStart_clr", vif.FrameStart, 0);
          chk("HMemRead_hold", vif.HMemRead, m_de(p));
        end
      end
      p++;
    end
    vif.PixEn = 1'b0;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_HMemRead"}, vif.HMemRead, 0);
    chk({tag, "_HVsync"}, vif.HVsync, 0);
    chk({tag, "_pVDE"}, vif.pVDE, 0);
    chk({tag, "_hsync"}, vif.hsync, 1);
    chk({tag, "_vsync"}, vif.vsync, 1);
    chk({tag, "_FrameStart"}, vif.FrameStart, 0);
  endtask

  initial begin
    rstn = 1'b0;
    vif.PixEn = 1'b0;
    vif.FraimSync = 1'b0;
    clr_track();
    repeat (3) @(posedge clk);
    #1 chk_rst("rst");
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_rst("idle");

    // line 2 pixel 5, then async reset mid-cycle
    run(38, 4);
    chk("pre_rst_HMemRead", vif.HMemRead, 1);
    chk("pre_rst_pVDE", vif.pVDE, 1);
    #2 rstn = 1'b0;
    #1 chk_rst("midrst");
    @(posedge clk); #1 rstn = 1'b1;
    @(posedge clk); #1;
    clr_track();

    run(FT, 4);
    chk("de_per_frame", cnt_de, HA * VA);

`ifdef FRAME_LOCK_EN
    for (int i = 0; i < 12; i++) begin
      vif.PixEn = 1'b1;
      @(posedge clk); #1 vif.PixEn = 1'b0;
      chk("wait_HMemRead", vif.HMemRead, 0);
      chk("wait_HVsync", vif.HVsync, 0);
      chk("wait_FrameStart", vif.FrameStart, 0);
      if (i >= RL) begin
        chk("wait_pVDE", vif.pVDE, 0);
        chk("wait_hsync", vif.hsync, 1);
        chk("wait_vsync", vif.vsync, 1);
      end
      repeat (4) @(posedge clk);
      #1;
    end
    vif.FraimSync = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clr_track();
    run(60, 4);
    vif.FraimSync = 1'b0;
    run(FT - 60 + 20, 4);
`else
    run(70, 4);
    vif.FraimSync = 1'b1;
    run(80, 4);
    vif.FraimSync = 1'b0;
    run(40, 0);
`endif

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
